risc_v_mike_gpio_bank: RTL and testbench

Parametrised multi-channel GPIO peripheral on the core's data MMIO bus; successor to the single fixed-width GPIO port. Each channel provides a registered output latch, per-bit direction control, atomic set/clear/toggle writes, synchronised inputs, and edge-triggered sticky interrupt status. All channels are OR-reduced into one interrupt line to the core.

---
 rtl/risc_v_mike_pkg.sv | 35 +++
 rtl/risc_v_mike_gpio_channel.sv | 115 +++++++++++
 rtl/risc_v_mike_gpio_bank.sv | 80 ++++++++
 tb/tb_risc_v_mike_gpio_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the risc_v_mike GPIO bank.
//   - Bus widths of the core's data MMIO port.
//   - Channel window stride and the register offsets inside one window.
//   - An enum of the same offsets, for decode and readable register names.
package risc_v_mike_pkg;

  localparam int ADDRESS_32_W = 32;
  localparam int DATA_32_W    = 32;

  // Each channel owns a 64-byte register window.
  localparam int GPIO_CH_STRIDE = 32'h40;

  localparam logic [5:0] GPIO_OFS_OUT        = 6'h00;
  localparam logic [5:0] GPIO_OFS_IN         = 6'h04;
  localparam logic [5:0] GPIO_OFS_DIR        = 6'h08;
  localparam logic [5:0] GPIO_OFS_OUT_SET    = 6'h0C;
  localparam logic [5:0] GPIO_OFS_OUT_CLR    = 6'h10;
  localparam logic [5:0] GPIO_OFS_OUT_TGL    = 6'h14;
  localparam logic [5:0] GPIO_OFS_RISE_EN    = 6'h18;
  localparam logic [5:0] GPIO_OFS_FALL_EN    = 6'h1C;
  localparam logic [5:0] GPIO_OFS_IRQ_STATUS = 6'h20;

  typedef enum logic [5:0] {
    GPIO_REG_OUT        = GPIO_OFS_OUT,
    GPIO_REG_IN         = GPIO_OFS_IN,
    GPIO_REG_DIR        = GPIO_OFS_DIR,
    GPIO_REG_OUT_SET    = GPIO_OFS_OUT_SET,
    GPIO_REG_OUT_CLR    = GPIO_OFS_OUT_CLR,
    GPIO_REG_OUT_TGL    = GPIO_OFS_OUT_TGL,
    GPIO_REG_RISE_EN    = GPIO_OFS_RISE_EN,
    GPIO_REG_FALL_EN    = GPIO_OFS_FALL_EN,
    GPIO_REG_IRQ_STATUS = GPIO_OFS_IRQ_STATUS
  } gpio_ofs_e;

endpackage

// File: rtl/risc_v_mike_gpio_channel.sv
// One GPIO channel: output latch, direction, atomic set/clear/toggle,
// input synchroniser with edge detection, and sticky interrupt status.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sel             this channel is addressed this cycle
//   wr_en           1 = write, 0 = read (qualified by sel)
//   ofs             byte offset inside the channel window
//   wr_data         write data, already trimmed to the channel width
//   pin_in          asynchronous pad inputs
//   rd_data         combinational read word, 0 when not read
//   out, oe         output latch and output enables
//   irq             OR of this channel's interrupt status bits
module risc_v_mike_gpio_channel
  import risc_v_mike_pkg::*;
#(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 wr_en,
  input  logic [5:0]           ofs,
  input  logic [GPIO_W-1:0]    wr_data,
  input  logic [GPIO_W-1:0]    pin_in,
  output logic [DATA_32_W-1:0] rd_data,
  output logic [GPIO_W-1:0]    out,
  output logic [GPIO_W-1:0]    oe,
  output logic                 irq
);

  logic [GPIO_W-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, prev_q;
  logic [GPIO_W-1:0] sync_p [SYNC_STAGES];
  logic [GPIO_W-1:0] sync_val, rise, fall, evt, out_nxt, status_clr;
  logic              do_wr, do_rd;
  logic              wr_out, wr_dir, wr_set, wr_clr, wr_tgl;
  logic              wr_rise, wr_fall, wr_stat;

  assign do_wr   = sel & wr_en;
  assign do_rd   = sel & ~wr_en;
  assign wr_out  = do_wr & (ofs == GPIO_OFS_OUT);
  assign wr_dir  = do_wr & (ofs == GPIO_OFS_DIR);
  assign wr_set  = do_wr & (ofs == GPIO_OFS_OUT_SET);
  assign wr_clr  = do_wr & (ofs == GPIO_OFS_OUT_CLR);
  assign wr_tgl  = do_wr & (ofs == GPIO_OFS_OUT_TGL);
  assign wr_rise = do_wr & (ofs == GPIO_OFS_RISE_EN);
  assign wr_fall = do_wr & (ofs == GPIO_OFS_FALL_EN);
  assign wr_stat = do_wr & (ofs == GPIO_OFS_IRQ_STATUS);

  assign sync_val   = sync_p[SYNC_STAGES-1];
  assign rise       = sync_val & ~prev_q;
  assign fall       = ~sync_val & prev_q;
  assign evt        = (rise & rise_en_q) | (fall & fall_en_q);
  assign status_clr = {GPIO_W{wr_stat}} & wr_data;

  // Set/clear/toggle act on the current latch, so consecutive-cycle
  // writes compose without any read-back by software.
  always_comb begin
    out_nxt = out_q;
    if (wr_out) out_nxt = wr_data;
    if (wr_set) out_nxt = out_q | wr_data;
    if (wr_clr) out_nxt = out_q & ~wr_data;
    if (wr_tgl) out_nxt = out_q ^ wr_data;
  end

  // Register stage: control/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      out_q <= out_nxt;
      if (wr_dir)  dir_q     <= wr_data;
      if (wr_rise) rise_en_q <= rise_en_q ^ (rise_en_q ^ wr_data);
      if (wr_fall) fall_en_q <= wr_data;
      // A new event ORs in after the clear, so it survives a same-cycle W1C.
      status_q <= (status_q & ~status_clr) | evt;
    end
  end

  // Synchroniser stages p0..pN-1, then the prev flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_p[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_q <= sync_val;
    end
  end

  always_comb begin
    rd_data = '0;
    if (do_rd) begin
      case (ofs)
        GPIO_OFS_OUT:        rd_data[GPIO_W-1:0] = out_q;
        GPIO_OFS_IN:         rd_data[GPIO_W-1:0] = sync_val;
        GPIO_OFS_DIR:        rd_data[GPIO_W-1:0] = dir_q;
        GPIO_OFS_RISE_EN:    rd_data[GPIO_W-1:0] = rise_en_q;
        GPIO_OFS_FALL_EN:    rd_data[GPIO_W-1:0] = fall_en_q;
        GPIO_OFS_IRQ_STATUS: rd_data[GPIO_W-1:0] = status_q;
        default:             rd_data = '0;
      endcase
    end
  end

  assign out = out_q;
  assign oe  = dir_q;
  assign irq = |status_q;

endmodule

// File: rtl/risc_v_mike_gpio_bank.sv
// Multi-channel GPIO peripheral on the core's data MMIO bus.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   data_mmio_addr          byte offset relative to the block base
//   data_mmio_wr_addr_val   access valid this cycle
//   data_mmio_wr_en         1 = write, 0 = read
//   data_mmio_wr_data       write data
//   data_mmio_rd_data       combinational read data (0 on write / no access)
//   gpio_port_in            pad inputs, channel c at [c*GPIO_W +: GPIO_W]
//   gpio_port_out           output latches
//   gpio_port_oe            output enables
//   gpio_irq                OR of every channel's interrupt status
module risc_v_mike_gpio_bank
  import risc_v_mike_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_32_W-1:0]  data_mmio_addr,
  input  logic                     data_mmio_wr_addr_val,
  input  logic                     data_mmio_wr_en,
  input  logic [DATA_32_W-1:0]     data_mmio_wr_data,
  output logic [DATA_32_W-1:0]     data_mmio_rd_data,
  input  logic [N_CH*GPIO_W-1:0]   gpio_port_in,
  output logic [N_CH*GPIO_W-1:0]   gpio_port_out,
  output logic [N_CH*GPIO_W-1:0]   gpio_port_oe,
  output logic                     gpio_irq
);

  logic [5:0]           ofs;
  logic [2:0]           ch_idx;
  logic                 in_window;
  logic [N_CH-1:0]      ch_sel;
  logic [N_CH-1:0]      ch_irq;
  logic [DATA_32_W-1:0] ch_rd [N_CH];

  // The block spans 8 channel windows (512 bytes); anything above is unmapped
  // rather than aliased.
  assign ofs       = data_mmio_addr[5:0];
  assign ch_idx    = data_mmio_addr[8:6];
  assign in_window = (data_mmio_addr[ADDRESS_32_W-1:9] == '0);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign ch_sel[c] = data_mmio_wr_addr_val & in_window & (ch_idx == 3'(c));

    risc_v_mike_gpio_channel #(
      .GPIO_W      (GPIO_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .sel     (ch_sel[c]),
      .wr_en   (data_mmio_wr_en),
      .ofs     (ofs),
      .wr_data (data_mmio_wr_data[GPIO_W-1:0]),
      .pin_in  (gpio_port_in[c*GPIO_W +: GPIO_W]),
      .rd_data (ch_rd[c]),
      .out     (gpio_port_out[c*GPIO_W +: GPIO_W]),
      .oe      (gpio_port_oe[c*GPIO_W +: GPIO_W]),
      .irq     (ch_irq[c])
    );
  end

  // Unselected channels drive 0, so an OR is a complete read mux.
  always_comb begin
    data_mmio_rd_data = '0;
    for (int i = 0; i < N_CH; i++) data_mmio_rd_data = data_mmio_rd_data | ch_rd[i];
  end

  assign gpio_irq = |ch_irq;

  if (GPIO_W < DATA_32_W) begin : g_wr_hi
    logic unused_wr_hi;
    assign unused_wr_hi = ^data_mmio_wr_data[DATA_32_W-1:GPIO_W];
  end

endmodule

// File: tb/tb_risc_v_mike_gpio_bank.sv
module tb_risc_v_mike_gpio_bank;
  import risc_v_mike_pkg::*;

  localparam int N_CH = 2;
  localparam int GPIO_W = 8;
  localparam int SYNC_STAGES = 2;
  localparam int PW = N_CH * GPIO_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr = '0;
  logic          val = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [PW-1:0] pin_in = '0;
  logic [PW-1:0] pin_out;
  logic [PW-1:0] pin_oe;
  logic          irq;

  risc_v_mike_gpio_bank #(
    .N_CH(N_CH), .GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .data_mmio_addr        (addr),
    .data_mmio_wr_addr_val (val),
    .data_mmio_wr_en       (wr),
    .data_mmio_wr_data     (wdata),
    .data_mmio_rd_data     (rdata),
    .gpio_port_in          (pin_in),
    .gpio_port_out         (pin_out),
    .gpio_port_oe          (pin_oe),
    .gpio_irq              (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum {K_RD, K_OUT, K_OE, K_IRQ} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  // Monitor: pops every expectation due this cycle and compares mid-cycle.
  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      case (it.kind)
        K_RD:    act = rdata;
        K_OUT:   act = 32'(pin_out);
        K_OE:    act = 32'(pin_oe);
        default: act = {31'b0, irq};
      endcase
      checks++;
      if (act !== it.exp || it.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, due %0d)",
                 it.name, act, it.exp, cyc, it.cyc);
      end
    end
  end

  task automatic expect_now(kind_e k, logic [31:0] e, string n);
    item_t it;
    it.cyc = cyc; it.kind = k; it.exp = e; it.name = n;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    val = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr_reg(logic [31:0] a, logic [31:0] d);
    val = 1'b1; wr = 1'b1; addr = a; wdata = d;
  endtask

  task automatic rd_reg(logic [31:0] a, logic [31:0] e, string n);
    val = 1'b1; wr = 1'b0; addr = a; wdata = '0;
    expect_now(K_RD, e, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  gpio_ofs_e   offs [9] = '{GPIO_REG_OUT, GPIO_REG_IN, GPIO_REG_DIR, GPIO_REG_OUT_SET,
                            GPIO_REG_OUT_CLR, GPIO_REG_OUT_TGL, GPIO_REG_RISE_EN,
                            GPIO_REG_FALL_EN, GPIO_REG_IRQ_STATUS};
  // Expected register contents after the simultaneous-event test and DIR1 write.
  logic [31:0] exp_ch0 [9] = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h01, 32'h08, 32'h00};
  logic [31:0] exp_ch1 [9] = '{32'h81, 32'h00, 32'h3C, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00};
  logic [31:0] bad_addr [7] = '{32'h24, 32'h64, 32'h80, 32'h01, 32'h41, 32'h42, 32'h9C};

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    expect_now(K_OUT, 32'h0, "reset_out");
    expect_now(K_OE,  32'h0, "reset_oe");
    expect_now(K_IRQ, 32'h0, "reset_irq");
    for (int c = 0; c < N_CH; c++) begin
      for (int i = 0; i < 9; i++) begin
        rd_reg(32'(c * GPIO_CH_STRIDE) + 32'(offs[i]), 32'h0,
               $sformatf("reset_ch%0d_%s", c, offs[i].name()));
        step();
      end
    end

    // OUT/SET/CLR/TGL on ch1, back to back
    wr_reg(32'h40, 32'hF0); expect_now(K_OUT, 32'h0000, "out_before_write"); step();
    wr_reg(32'h4C, 32'h0F); expect_now(K_OUT, 32'hF000, "out_write");        step();
    wr_reg(32'h50, 32'h81); expect_now(K_OUT, 32'hFF00, "out_set");          step();
    wr_reg(32'h54, 32'hFF); expect_now(K_OUT, 32'h7E00, "out_clr");          step();
    rd_reg(32'h40, 32'h81, "out_tgl_read"); expect_now(K_OUT, 32'h8100, "out_tgl"); step();
    rd_reg(32'h4C, 32'h0, "wo_set_reads_0"); step();

    // IN latency on ch0
    pin_in[7:0] = 8'h5A;
    rd_reg(32'h04, 32'h00, "in_cycle0"); step();
    rd_reg(32'h04, 32'h00, "in_cycle1"); step();
    rd_reg(32'h04, 32'h5A, "in_cycle2"); step();
    pin_in[7:0] = 8'h00; idle();
    repeat (4) step();

    // Rising-edge IRQ on ch0 pin 0
    wr_reg(32'h18, 32'h01); step();
    pin_in[0] = 1'b1; idle();
    expect_now(K_IRQ, 32'h0, "irq_c0"); step();
    step();
    rd_reg(32'h20, 32'h00, "stat_c2"); expect_now(K_IRQ, 32'h0, "irq_c2"); step();
    rd_reg(32'h20, 32'h01, "stat_c3"); expect_now(K_IRQ, 32'h1, "irq_c3"); step();
    pin_in[0] = 1'b0; idle();
    repeat (4) step();
    rd_reg(32'h20, 32'h01, "stat_after_fall"); step();
    wr_reg(32'h20, 32'h01); step();
    rd_reg(32'h20, 32'h00, "stat_w1c"); expect_now(K_IRQ, 32'h0, "irq_w1c"); step();

    // Fall event on pin 3 coinciding with W1C of bit 3
    wr_reg(32'h1C, 32'h08); step();
    pin_in[3] = 1'b1; idle();
    repeat (4) step();
    rd_reg(32'h20, 32'h00, "stat_pre_fall"); step();
    pin_in[3] = 1'b0;
    rd_reg(32'h20, 32'h00, "stat_g0"); step();
    rd_reg(32'h20, 32'h00, "stat_g1"); step();
    wr_reg(32'h20, 32'h08); step();
    rd_reg(32'h20, 32'h08, "set_wins"); expect_now(K_IRQ, 32'h1, "irq_set_wins"); step();
    wr_reg(32'h20, 32'h08); step();
    rd_reg(32'h20, 32'h00, "stat_clr3"); step();

    // DIR and decode boundaries
    wr_reg(32'h48, 32'h3C); step();
    rd_reg(32'h48, 32'h3C, "dir1_read"); expect_now(K_OE, 32'h3C00, "dir1_oe"); step();
    for (int i = 0; i < 7; i++) begin
      rd_reg(bad_addr[i], 32'h0, $sformatf("unmapped_rd_%02h", bad_addr[i]));
      step();
    end
    for (int i = 0; i < 7; i++) begin
      wr_reg(bad_addr[i], 32'hFFFF_FFFF);
      step();
    end
    expect_now(K_OUT, 32'h8100, "out_after_bad_wr");
    expect_now(K_OE,  32'h3C00, "oe_after_bad_wr");
    for (int i = 0; i < 9; i++) begin
      rd_reg(32'(offs[i]), exp_ch0[i], $sformatf("keep_ch0_%s", offs[i].name()));
      step();
      rd_reg(32'h40 + 32'(offs[i]), exp_ch1[i], $sformatf("keep_ch1_%s", offs[i].name()));
      step();
    end
    wr_reg(32'h00, 32'hFFFF_FFFF); step();
    rd_reg(32'h00, 32'h0000_00FF, "out_width_mask"); expect_now(K_OUT, 32'h81FF, "out_mask_pins"); step();

    // IRQ from ch1 reaches the shared line
    wr_reg(32'h58, 32'h80); step();
    pin_in[15] = 1'b1; idle();
    step(); step(); step();
    rd_reg(32'h60, 32'h80, "ch1_stat"); expect_now(K_IRQ, 32'h1, "ch1_irq"); step();

    // Asynchronous reset mid-operation
    idle();
    rst = 1'b1;
    #1;
    rd_reg(32'h40, 32'h0, "arst_out1_read");
    expect_now(K_OUT, 32'h0, "arst_out");
    expect_now(K_OE,  32'h0, "arst_oe");
    expect_now(K_IRQ, 32'h0, "arst_irq");
    step();
    rst = 1'b0; idle();
    repeat (2) step();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
